// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  // True for ops that run the 32-step loop.
  function automatic logic isIterOp(input logic [2:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MUL: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

  // True for ops whose operands are taken as two's-complement magnitudes.
  function automatic logic isSignedOp(input logic [2:0] op);
    logic r;
    case (op)
      OP_MULT, OP_DIV, OP_MUL: r = 1'b1;
      default:                 r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Datapath: shared accumulator for shift-add multiply and restoring divide,
// plus the final sign correction of product, quotient and remainder.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               mulStep,
  input  logic               divStep,
  input  logic [WIDTH-1:0]   opA,
  input  logic [WIDTH-1:0]   opB,
  input  logic               negRes,
  input  logic               negQ,
  input  logic               negR,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder
);

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc low half = dividend bits shifting out / quotient bits shifting in.
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   md_r;
  logic [WIDTH-1:0]   rem_r;

  logic [WIDTH:0]     mulSum_s;
  logic [WIDTH:0]     divShift_s;
  logic [WIDTH:0]     divDiff_s;

  // One shift-add and one trial-subtract step, both computed every cycle.
  always_comb begin
    mulSum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                 (acc_r[0] ? {1'b0, md_r} : {(WIDTH+1){1'b0}});
    divShift_s = {rem_r, acc_r[WIDTH-1]};
    divDiff_s  = divShift_s - {1'b0, md_r};
  end

  // Operand load and per-cycle iteration of the selected algorithm.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {(2*WIDTH){1'b0}};
      md_r  <= {WIDTH{1'b0}};
      rem_r <= {WIDTH{1'b0}};
    end else if (load) begin
      acc_r <= {{WIDTH{1'b0}}, opA};
      md_r  <= opB;
      rem_r <= {WIDTH{1'b0}};
    end else if (mulStep) begin
      acc_r <= {mulSum_s, acc_r[WIDTH-1:1]};
    end else if (divStep) begin
      // A non-negative difference means the divisor fits: keep it, quotient bit 1.
      if (!divDiff_s[WIDTH]) begin
        rem_r <= divDiff_s[WIDTH-1:0];
        acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        rem_r <= divShift_s[WIDTH-1:0];
        acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_r <= acc_r;
    end
  end

  // Sign fix applied to the finished magnitudes.
  always_comb begin
    product   = negRes ? -acc_r : acc_r;
    quotient  = negQ ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    remainder = negR ? -rem_r : rem_r;
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multiply/divide sequencer: FSM, iteration counter, sign flags, HI/LO and
// mulOut registers, and the pipeline stall request.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             readHiLo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mulOut
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntZero = {CntW{1'b0}};
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_r;
  logic [CntW-1:0]  cnt_r;
  logic [2:0]       opSave_r;
  logic             negRes_r;
  logic             negQ_r;
  logic             negR_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] mulOut_r;

  logic [WIDTH-1:0]   absA_s;
  logic [WIDTH-1:0]   absB_s;
  logic               iterLoad_s;
  logic [2*WIDTH-1:0] product_s;
  logic [WIDTH-1:0]   quotient_s;
  logic [WIDTH-1:0]   remainder_s;

  // Signed ops feed magnitudes into the loop; the sign is restored in FIX.
  always_comb begin
    absA_s = a;
    absB_s = b;
    if (isSignedOp(op)) begin
      absA_s = a[WIDTH-1] ? -a : a;
      absB_s = b[WIDTH-1] ? -b : b;
    end else begin
      absA_s = a;
      absB_s = b;
    end
  end

  assign iterLoad_s = (state_r == ST_IDLE) && start && isIterOp(op);

  muldiv_iter #(.WIDTH(WIDTH)) uIter (
    .clk       (clk),
    .rst       (rst),
    .load      (iterLoad_s),
    .mulStep   (state_r == ST_MUL),
    .divStep   (state_r == ST_DIV),
    .opA       (absA_s),
    .opB       (absB_s),
    .negRes    (negRes_r),
    .negQ      (negQ_r),
    .negR      (negR_r),
    .product   (product_s),
    .quotient  (quotient_s),
    .remainder (remainder_s)
  );

  // Sequencer FSM with its counter, sign flags and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CntZero;
      opSave_r <= 3'd0;
      negRes_r <= 1'b0;
      negQ_r   <= 1'b0;
      negR_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      mulOut_r <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MUL, OP_MULTU: begin
                negRes_r <= isSignedOp(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
                opSave_r <= op;
                cnt_r    <= CntLast;
                busy_r   <= 1'b1;
                state_r  <= ST_MUL;
              end
              OP_DIV, OP_DIVU: begin
                negQ_r   <= isSignedOp(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
                negR_r   <= isSignedOp(op) & a[WIDTH-1];
                opSave_r <= op;
                cnt_r    <= CntLast;
                busy_r   <= 1'b1;
                state_r  <= ST_DIV;
              end
              OP_MTHI: hi_r <= a;
              OP_MTLO: lo_r <= a;
              default: state_r <= ST_IDLE;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          if (cnt_r == CntZero) begin
            state_r <= ST_FIX;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CntOne;
          end
        end
        ST_FIX: begin
          case (opSave_r)
            OP_MUL: mulOut_r <= product_s[WIDTH-1:0];
            OP_MULT, OP_MULTU: begin
              hi_r <= product_s[2*WIDTH-1:WIDTH];
              lo_r <= product_s[WIDTH-1:0];
            end
            OP_DIV, OP_DIVU: begin
              hi_r <= remainder_s;
              lo_r <= quotient_s;
            end
            default: hi_r <= hi_r;
          endcase
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign hi     = hi_r;
  assign lo     = lo_r;
  assign mulOut = mulOut_r;
  assign stall  = busy_r & (start | readHiLo);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: vector table of ops with hand-computed
// HI/LO/mulOut, plus stall, idle-read and mid-op reset sequences.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        readHiLo = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo, mulOut;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        iter;
    logic [31:0] eHi;
    logic [31:0] eLo;
    logic [31:0] eMul;
  } vec_t;

  vec_t vecs[13];

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .readHiLo(readHiLo), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo), .mulOut(mulOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present an op in the current cycle; returns one cycle later (#1 after edge).
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Check busy/done over T+1..T+33 and results at T+34.
  task automatic runIter(input logic [31:0] eHi, input logic [31:0] eLo, input logic [31:0] eMul);
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (c < 34) begin
        chk($sformatf("busy@T+%0d", c), {31'd0, busy}, 32'd1);
        chk($sformatf("done@T+%0d", c), {31'd0, done}, (c == 33) ? 32'd1 : 32'd0);
      end else begin
        chk("busy@T+34", {31'd0, busy}, 32'd0);
        chk("done@T+34", {31'd0, done}, 32'd0);
        chk("hi", hi, eHi);
        chk("lo", lo, eLo);
        chk("mulOut", mulOut, eMul);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int doneSeen;
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 32'h00000001, 32'h00000000};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'h00000000};
    vecs[2]  = '{OP_MUL,   32'h00000007, 32'hFFFFFFFA, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFD6};
    vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFD6};
    vecs[4]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h80000000, 32'hFFFFFFD6};
    vecs[5]  = '{OP_DIVU,  32'h0000000A, 32'h00000000, 1'b1, 32'h0000000A, 32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[6]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 1'b1, 32'h00000001, 32'h00000000, 32'hFFFFFFD6};
    vecs[7]  = '{OP_DIV,   32'h00000064, 32'hFFFFFFF9, 1'b1, 32'h00000002, 32'hFFFFFFF2, 32'hFFFFFFD6};
    vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 1'b1, 32'h0000000F, 32'h0FFFFFFF, 32'hFFFFFFD6};
    vecs[9]  = '{OP_MUL,   32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 32'h0000000F, 32'h0FFFFFFF, 32'h00000010};
    vecs[10] = '{OP_MTHI,  32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'h0FFFFFFF, 32'h00000010};
    vecs[11] = '{OP_MTLO,  32'h00ABCDEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'h00ABCDEF, 32'h00000010};
    vecs[12] = '{3'd7,     32'h12345678, 32'h00000000, 1'b0, 32'hDEADBEEF, 32'h00ABCDEF, 32'h00000010};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst mulOut", mulOut, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Vector table
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      if (vecs[i].iter) begin
        runIter(vecs[i].eHi, vecs[i].eLo, vecs[i].eMul);
      end else begin
        @(negedge clk);
        chk($sformatf("v%0d busy", i), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d done", i), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d hi", i), hi, vecs[i].eHi);
        chk($sformatf("v%0d lo", i), lo, vecs[i].eLo);
        chk($sformatf("v%0d mulOut", i), mulOut, vecs[i].eMul);
        @(posedge clk); #1;
      end
    end

    // Stall: read and a competing MTLO held during a DIVU 20/3
    issue(OP_DIVU, 32'd20, 32'd3);
    start = 1'b1; op = OP_MTLO; a = 32'h00001234; readHiLo = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      chk($sformatf("stall@T+%0d", c), {31'd0, stall}, 32'd1);
      chk($sformatf("lo held@T+%0d", c), lo, 32'h00ABCDEF);
    end
    @(posedge clk); #1;
    start = 1'b0; readHiLo = 1'b0;
    @(negedge clk);
    chk("div20/3 busy", {31'd0, busy}, 32'd0);
    chk("div20/3 stall", {31'd0, stall}, 32'd0);
    chk("div20/3 hi", hi, 32'd2);
    chk("div20/3 lo", lo, 32'd6);
    @(posedge clk); #1;
    issue(OP_MTLO, 32'h00001234, 32'd0);
    @(negedge clk);
    chk("mtlo after div", lo, 32'h00001234);
    @(posedge clk); #1;

    // Idle read with simultaneous start
    issue(OP_MTHI, 32'h00000055, 32'd0);
    @(negedge clk);
    chk("mthi 55", hi, 32'h00000055);
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd9; readHiLo = 1'b1;
    @(negedge clk);
    chk("idle read stall", {31'd0, stall}, 32'd0);
    chk("idle read hi", hi, 32'h00000055);
    @(posedge clk); #1;
    start = 1'b0; readHiLo = 1'b0;
    runIter(32'd1, 32'd11, 32'h00000010);

    // Reset in the middle of a MULT
    issue(OP_MULT, 32'd3, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre-rst busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-rst busy", {31'd0, busy}, 32'd0);
    chk("mid-rst hi", hi, 32'd0);
    chk("mid-rst lo", lo, 32'd0);
    chk("mid-rst mulOut", mulOut, 32'd0);
    doneSeen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    chk("mid-rst no done", doneSeen, 32'd0);
    chk("mid-rst idle busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
